// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams and UART transmitter strobe/busy, bundled for the arbiter.
// master is the arbiter view; slave is the requester/transmitter environment view.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0]   i_req_valid;
    logic [8*N_REQ-1:0] i_req_data;
    logic [N_REQ-1:0]   i_req_last;
    logic [N_REQ-1:0]   o_req_ready;
    logic [N_REQ-1:0]   o_grant;
    logic               o_active;
    logic               o_tx_write;
    logic [7:0]         o_tx_data;
    logic               i_tx_busy;
    logic               o_abort;

    modport master (
        input  i_req_valid, i_req_data, i_req_last, i_tx_busy,
        output o_req_ready, o_grant, o_active, o_tx_write, o_tx_data, o_abort
    );

    modport slave (
        output i_req_valid, i_req_data, i_req_last, i_tx_busy,
        input  o_req_ready, o_grant, o_active, o_tx_write, o_tx_data, o_abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between N_REQ byte streams.
// Define UART_ARB_WDOG_EN to abort a locked packet after TIMEOUT idle cycles in FETCH.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = 11
) (
    input logic            i_clk,
    input logic            rstn,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWaitHi, StWaitLo} state_e;

    state_e           state_q;
    logic [IW-1:0]    rr_q;
    logic [IW-1:0]    gidx_q;
    logic [N_REQ-1:0] grant_q;
    logic             active_q;
    logic             tx_write_q;
    logic [7:0]       tx_data_q;
    logic             last_q;
    logic             hi_cnt_q;

    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    cand;
    logic             g_valid;
    logic             g_last;
    logic [7:0]       g_data;

    // Search rr+1, rr+2, ... with wrap so the last owner has lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IW'((32'(rr_q) + i) % N_REQ);
            if (!pick_found && bus.i_req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign g_valid = bus.i_req_valid[gidx_q];
    assign g_last  = bus.i_req_last[gidx_q];
    assign g_data  = bus.i_req_data[{gidx_q, 3'b000} +: 8];

    assign bus.o_req_ready = (state_q == StFetch) ? (grant_q & bus.i_req_valid) : '0;
    assign bus.o_grant     = grant_q;
    assign bus.o_active    = active_q;
    assign bus.o_tx_write  = tx_write_q;
    assign bus.o_tx_data   = tx_data_q;

`ifdef UART_ARB_WDOG_EN
    logic [TW-1:0] wd_q;
    logic          abort_q;
    assign bus.o_abort = abort_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^{TIMEOUT, TW};
    assign bus.o_abort = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            rr_q       <= IW'(N_REQ - 1);
            gidx_q     <= '0;
            grant_q    <= '0;
            active_q   <= 1'b0;
            tx_write_q <= 1'b0;
            tx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            hi_cnt_q   <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            wd_q       <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            tx_write_q <= 1'b0;
`ifdef UART_ARB_WDOG_EN
            abort_q    <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (pick_found && !bus.i_tx_busy) begin
                        gidx_q   <= pick_idx;
                        grant_q  <= N_REQ'(1) << pick_idx;
                        active_q <= 1'b1;
                        state_q  <= StFetch;
`ifdef UART_ARB_WDOG_EN
                        wd_q     <= '0;
`endif
                    end
                end
                StFetch: begin
                    if (g_valid) begin
                        tx_data_q  <= g_data;
                        last_q     <= g_last;
                        tx_write_q <= 1'b1;
                        state_q    <= StIssue;
`ifdef UART_ARB_WDOG_EN
                    end else if (wd_q == TW'(TIMEOUT - 1)) begin
                        abort_q  <= 1'b1;
                        rr_q     <= gidx_q;
                        grant_q  <= '0;
                        active_q <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                StIssue: begin
                    hi_cnt_q <= 1'b0;
                    state_q  <= StWaitHi;
                end
                StWaitHi: begin
                    // A transmitter that never raises busy is treated as done after 2 cycles.
                    if (bus.i_tx_busy || hi_cnt_q) begin
                        state_q <= StWaitLo;
                    end else begin
                        hi_cnt_q <= 1'b1;
                    end
                end
                StWaitLo: begin
                    if (!bus.i_tx_busy) begin
                        if (last_q) begin
                            rr_q     <= gidx_q;
                            grant_q  <= '0;
                            active_q <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            state_q  <= StFetch;
`ifdef UART_ARB_WDOG_EN
                            wd_q     <= '0;
`endif
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: packet table plus lock/pacing/reset/watchdog sequences.
// Requesters, transmitter busy model and write monitor all advance in step().
module tb_uart_tx_arbiter;
    localparam int unsigned N = 4;
`ifdef UART_ARB_WDOG_EN
    localparam int unsigned TO  = 16;
    localparam int unsigned TWB = 5;
`else
    localparam int unsigned TO  = 1024;
    localparam int unsigned TWB = 11;
`endif

    typedef struct packed {
        logic [3:0][1:0]      len;
        logic [3:0][2:0][7:0] bytes;
        logic [3:0]           exp_n;
        logic [7:0][7:0]      exp_data;
        logic [7:0][1:0]      exp_req;
        logic [7:0]           exp_gap;
    } vec_t;

    logic clk;
    logic rstn;
    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO), .TW(TWB)) dut (
        .i_clk (clk),
        .rstn  (rstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [8:0] rbuf [N][16];
    int rhead [N];
    int rtail [N];
    int gap [N];
    int gap_cfg [N];

    int busy_len = 20;
    int busy_cnt = 0;
    logic tx_hold = 1'b0;

    logic [7:0] wdata [64];
    int widx [64];
    int wcyc [64];
    int wn = 0;
    int abort_n = 0;
    int abort_cyc = 0;
    logic [3:0] abort_grant = '0;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic last);
        rbuf[k][rtail[k] % 16] = {last, d};
        rtail[k]++;
    endtask

    function automatic logic all_empty();
        for (int k = 0; k < N; k++) if (rhead[k] != rtail[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bus.i_req_valid[k] = (rhead[k] != rtail[k]) && (gap[k] == 0);
            {bus.i_req_last[k], bus.i_req_data[8*k +: 8]} = rbuf[k][rhead[k] % 16];
        end
    endtask

    task automatic flush();
        for (int k = 0; k < N; k++) begin
            rhead[k] = 0;
            rtail[k] = 0;
            gap[k] = 0;
        end
        drive();
    endtask

    // One clock: monitor at the negedge, then advance the models just after the posedge.
    task automatic step();
        logic [3:0] acc;
        logic wr;
        int id;
        @(negedge clk);
        acc = bus.o_req_ready;
        wr = bus.o_tx_write;
        if (wr === 1'b1) begin
            check("write_while_busy", 32'(bus.i_tx_busy), 0);
            check("grant_onehot", 32'($onehot(bus.o_grant)), 1);
            id = -1;
            for (int j = 0; j < N; j++) if (bus.o_grant[j]) id = j;
            if (wn < 64) begin
                wdata[wn] = bus.o_tx_data;
                widx[wn] = id;
                wcyc[wn] = cyc;
                wn++;
            end
        end
        if (bus.o_abort === 1'b1) begin
            abort_n++;
            abort_cyc = cyc;
            abort_grant = bus.o_grant;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (gap[k] > 0) gap[k]--;
            if (acc[k] === 1'b1 && rhead[k] != rtail[k]) begin
                if (!rbuf[k][rhead[k] % 16][8]) gap[k] = gap_cfg[k];
                rhead[k]++;
            end
        end
        if (busy_cnt > 0) busy_cnt--;
        if (wr === 1'b1) busy_cnt = busy_len;
        bus.i_tx_busy = tx_hold || (busy_cnt > 0);
        drive();
    endtask

    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (i < 3000 && !(all_empty() && !bus.o_active && !bus.i_tx_busy)) begin
            step();
            i++;
        end
        check({name, "_done"}, 32'(i < 3000), 1);
        step();
        step();
    endtask

    task automatic wait_writes(input int n);
        int i;
        i = 0;
        while (i < 3000 && wn < n) begin
            step();
            i++;
        end
        check("wait_writes", 32'(wn >= n), 1);
    endtask

    task automatic vpkt(input int v, input int k, input int n,
                        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        vecs[v].len[k] = 2'(n);
        vecs[v].bytes[k][0] = b0;
        vecs[v].bytes[k][1] = b1;
        vecs[v].bytes[k][2] = b2;
    endtask

    task automatic vexp(input int v, input int r, input logic [7:0] d);
        vecs[v].exp_data[vecs[v].exp_n] = d;
        vecs[v].exp_req[vecs[v].exp_n] = 2'(r);
        vecs[v].exp_n = vecs[v].exp_n + 4'd1;
    endtask

    task automatic check_log(input string name, input int n,
                             input int r0, input logic [7:0] d0, input int r1, input logic [7:0] d1,
                             input int r2, input logic [7:0] d2, input int r3, input logic [7:0] d3);
        int rs [4];
        logic [7:0] ds [4];
        rs = '{r0, r1, r2, r3};
        ds = '{d0, d1, d2, d3};
        check({name, "_count"}, 32'(wn), 32'(n));
        for (int i = 0; i < n; i++) begin
            check({name, "_data"}, 32'(wdata[i]), 32'(ds[i]));
            check({name, "_req"}, 32'(widx[i]), 32'(rs[i]));
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            gap_cfg[k] = 0;
            for (int b = 0; b < 16; b++) rbuf[k][b] = '0;
        end
        for (int v = 0; v < 5; v++) vecs[v] = '0;
        // Expected orders assume rr carries over from one vector to the next (reset rr=3).
        vpkt(0, 0, 1, 8'h10, 8'h00, 8'h00); vpkt(0, 1, 1, 8'h11, 8'h00, 8'h00);
        vpkt(0, 2, 1, 8'h12, 8'h00, 8'h00); vpkt(0, 3, 1, 8'h13, 8'h00, 8'h00);
        vexp(0, 0, 8'h10); vexp(0, 1, 8'h11); vexp(0, 2, 8'h12); vexp(0, 3, 8'h13);
        vpkt(1, 0, 1, 8'h20, 8'h00, 8'h00); vpkt(1, 2, 1, 8'h22, 8'h00, 8'h00);
        vexp(1, 0, 8'h20); vexp(1, 2, 8'h22);
        vpkt(2, 0, 2, 8'h41, 8'h42, 8'h00);
        vexp(2, 0, 8'h41); vexp(2, 0, 8'h42);
        vecs[2].exp_gap = 8'd23;
        vpkt(3, 0, 1, 8'hC0, 8'h00, 8'h00); vpkt(3, 1, 3, 8'hA1, 8'hA2, 8'hA3);
        vpkt(3, 3, 2, 8'hB1, 8'hB2, 8'h00);
        vexp(3, 1, 8'hA1); vexp(3, 1, 8'hA2); vexp(3, 1, 8'hA3);
        vexp(3, 3, 8'hB1); vexp(3, 3, 8'hB2); vexp(3, 0, 8'hC0);
        vecs[3].exp_gap = 8'd23;
        vpkt(4, 3, 1, 8'hD0, 8'h00, 8'h00); vpkt(4, 1, 1, 8'hD1, 8'h00, 8'h00);
        vexp(4, 1, 8'hD1); vexp(4, 3, 8'hD0);

        rstn = 1'b0;
        bus.i_tx_busy = 1'b0;
        flush();
        repeat (3) step();
        check("rst_grant", 32'(bus.o_grant), 0);
        check("rst_active", 32'(bus.o_active), 0);
        check("rst_write", 32'(bus.o_tx_write), 0);
        check("rst_data", 32'(bus.o_tx_data), 0);
        check("rst_ready", 32'(bus.o_req_ready), 0);
        check("rst_abort", 32'(bus.o_abort), 0);
        rstn = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            wn = 0;
            for (int k = 0; k < N; k++)
                for (int b = 0; b < int'(vecs[v].len[k]); b++)
                    push(k, vecs[v].bytes[k][b], b == int'(vecs[v].len[k]) - 1);
            drive();
            wait_done("vec");
            check("vec_count", 32'(wn), 32'(vecs[v].exp_n));
            for (int i = 0; i < int'(vecs[v].exp_n); i++) begin
                check("vec_data", 32'(wdata[i]), 32'(vecs[v].exp_data[i]));
                check("vec_req", 32'(widx[i]), 32'(vecs[v].exp_req[i]));
            end
            if (vecs[v].exp_gap != 0 && wn >= 2)
                check("vec_gap", 32'(wcyc[1] - wcyc[0]), 32'(vecs[v].exp_gap));
        end

        // Lock hold: req1 goes silent between bytes, req2 must not slip in.
        wn = 0;
        gap_cfg[1] = 30;
        push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
        push(2, 8'h40, 1'b1);
        drive();
        wait_done("lock");
        check_log("lock", 4, 1, 8'h31, 1, 8'h32, 1, 8'h33, 2, 8'h40);
        if (wn >= 2) check("lock_gap", 32'(wcyc[1] - wcyc[0]), 31);
        gap_cfg[1] = 0;

        // Busy pacing: no grant or write while the transmitter reports busy.
        wn = 0;
        tx_hold = 1'b1;
        step();
        push(0, 8'h55, 1'b1);
        drive();
        repeat (30) step();
        check("hold_writes", 32'(wn), 0);
        check("hold_active", 32'(bus.o_active), 0);
        tx_hold = 1'b0;
        wait_done("hold");
        check_log("hold", 1, 0, 8'h55, 0, 8'h00, 0, 8'h00, 0, 8'h00);

        // Transmitter never raises busy: WAIT_HI gives up after 2 cycles.
        wn = 0;
        busy_len = 0;
        push(0, 8'h61, 1'b0); push(0, 8'h62, 1'b1);
        drive();
        wait_done("nobusy");
        check_log("nobusy", 2, 0, 8'h61, 0, 8'h62, 0, 8'h00, 0, 8'h00);
        if (wn >= 2) check("nobusy_gap", 32'(wcyc[1] - wcyc[0]), 5);
        busy_len = 20;

        // Reset during WAIT_LO of byte 2 of 4.
        wn = 0;
        push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b0); push(0, 8'h73, 1'b0); push(0, 8'h74, 1'b1);
        drive();
        wait_writes(2);
        repeat (5) step();
        check("mid_active_pre", 32'(bus.o_active), 1);
        rstn = 1'b0;
        flush();
        step();
        check("mid_rst_grant", 32'(bus.o_grant), 0);
        check("mid_rst_active", 32'(bus.o_active), 0);
        check("mid_rst_write", 32'(bus.o_tx_write), 0);
        rstn = 1'b1;
        wn = 0;
        push(1, 8'h81, 1'b1); push(3, 8'h83, 1'b1); push(0, 8'h80, 1'b1);
        drive();
        wait_done("postrst");
        check_log("postrst", 3, 0, 8'h80, 1, 8'h81, 3, 8'h83, 0, 8'h00);

`ifdef UART_ARB_WDOG_EN
        // req2 stalls mid-packet; watchdog fires 16 cycles into FETCH and req3 follows.
        wn = 0;
        push(2, 8'hE0, 1'b0);
        drive();
        wait_writes(1);
        push(3, 8'hF3, 1'b1);
        drive();
        begin
            int i;
            i = 0;
            while (i < 200 && abort_n == 0) begin
                step();
                i++;
            end
        end
        check("wd_fired", 32'(abort_n), 1);
        check("wd_cycle", 32'(abort_cyc), 32'(wcyc[0] + 38));
        check("wd_grant", 32'(abort_grant), 0);
        step();
        check("wd_pulse", 32'(bus.o_abort), 0);
        wait_done("wd");
        check_log("wd", 2, 2, 8'hE0, 3, 8'hF3, 0, 8'h00, 0, 8'h00);
        check("wd_single", 32'(abort_n), 1);
`else
        check("no_abort", 32'(abort_n), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
